// File: rtl/sensor_buf_axi_slave.sv
// sensor_buf_axi_slave: AXI4 slave with a DEPTH-entry sensor sample buffer and CTRL/CLEAR/STATUS/THRESH registers.
// Define SCTRL_THRESH_EN to make the interrupt threshold programmable; otherwise it is fixed at DEPTH.
module sensor_buf_axi_slave #(
    parameter int DEPTH = 64,
    parameter int IDW   = 8
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic            sensor_ready,
    input  logic [31:0]     sensor_out,
    output logic            sensor_en,
    output logic            sctrl_interrupt,
    input  logic [IDW-1:0]  AWID_S,
    input  logic [31:0]     AWADDR_S,
    input  logic [3:0]      AWLEN_S,
    input  logic [2:0]      AWSIZE_S,
    input  logic [1:0]      AWBURST_S,
    input  logic            AWVALID_S,
    output logic            AWREADY_S,
    input  logic [31:0]     WDATA_S,
    input  logic [3:0]      WSTRB_S,
    input  logic            WLAST_S,
    input  logic            WVALID_S,
    output logic            WREADY_S,
    output logic [IDW-1:0]  BID_S,
    output logic [1:0]      BRESP_S,
    output logic            BVALID_S,
    input  logic            BREADY_S,
    input  logic [IDW-1:0]  ARID_S,
    input  logic [31:0]     ARADDR_S,
    input  logic [3:0]      ARLEN_S,
    input  logic [2:0]      ARSIZE_S,
    input  logic [1:0]      ARBURST_S,
    input  logic            ARVALID_S,
    output logic            ARREADY_S,
    output logic [IDW-1:0]  RID_S,
    output logic [31:0]     RDATA_S,
    output logic [1:0]      RRESP_S,
    output logic            RLAST_S,
    output logic            RVALID_S,
    input  logic            RREADY_S
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    typedef enum logic {R_IDLE, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    logic [31:0] mem_q [DEPTH];
    logic en_q, en_d, clr, cap, wbeat, reg_we, wr_ok, werr_q, werr_d, rerr_q, rerr_d;
    logic [CW-1:0] count_q, count_d, thr;
    logic [AW-1:0] wptr_q, wptr_d;
    rstate_t rstate_q, rstate_d;
    wstate_t wstate_q, wstate_d;
    logic [IDW-1:0] rid_q, rid_d, bid_q, bid_d;
    logic [3:0] rlen_q, rlen_d;
    logic [9:0] raddr_q, raddr_d, waddr_q, waddr_d;
    logic [1:0] rburst_q, rburst_d, wburst_q, wburst_d;
    logic [31:0] rdata_q, rdata_d;
    logic unused_ok;
    assign unused_ok = ^{AWSIZE_S, ARSIZE_S, AWLEN_S, AWADDR_S[31:12], AWADDR_S[1:0],
                         ARADDR_S[31:12], ARADDR_S[1:0], WDATA_S[31:1], WSTRB_S[3:1]};
    // Word-addressed decode; returns {slverr, data}
    function automatic logic [32:0] rd_word(input logic [9:0] idx);
        if (idx < 10'(DEPTH)) return {1'b0, mem_q[idx[AW-1:0]]};
        case (idx)
            10'h200: return {32'b0, en_q};
            10'h201: return 33'b0;
            10'h202: return {1'b0, 32'(count_q)};
            10'h203: return {1'b0, 32'(thr)};
            default: return {1'b1, 32'b0};
        endcase
    endfunction
    assign sensor_en       = en_q && (count_q < DEPTH_C);
    assign sctrl_interrupt = count_q >= thr;
    assign cap     = sensor_en && sensor_ready;
    assign wbeat   = (wstate_q == W_DATA) && WVALID_S;
    assign reg_we  = wbeat && WSTRB_S[0];
    assign wr_ok   = (waddr_q == 10'h200) || (waddr_q == 10'h201) || (waddr_q == 10'h203);
    assign en_d    = (reg_we && waddr_q == 10'h200) ? WDATA_S[0] : en_q;
    assign clr     = reg_we && (waddr_q == 10'h201) && WDATA_S[0];
    assign count_d = clr ? '0 : cap ? count_q + CW'(1) : count_q;
    assign wptr_d  = clr ? '0 : cap ? wptr_q + AW'(1) : wptr_q;
`ifdef SCTRL_THRESH_EN
    logic [CW-1:0] thr_q, thr_d;
    assign thr   = thr_q;
    assign thr_d = !(reg_we && waddr_q == 10'h203) ? thr_q :
                   (WDATA_S == 32'd0) ? CW'(1) :
                   (WDATA_S > 32'(DEPTH)) ? DEPTH_C : WDATA_S[CW-1:0];
    always_ff @(posedge ACLK) thr_q <= ARESET ? DEPTH_C : thr_d;
`else
    assign thr = DEPTH_C;
`endif
    always_comb begin
        rstate_d = rstate_q;
        rid_d    = rid_q;
        rlen_d   = rlen_q;
        raddr_d  = raddr_q;
        rburst_d = rburst_q;
        {rerr_d, rdata_d} = {rerr_q, rdata_q};
        if (rstate_q == R_IDLE && ARVALID_S) begin
            rstate_d = R_DATA;
            rid_d    = ARID_S;
            rlen_d   = ARLEN_S;
            raddr_d  = ARADDR_S[11:2];
            rburst_d = ARBURST_S;
            {rerr_d, rdata_d} = rd_word(ARADDR_S[11:2]);
        end else if (rstate_q == R_DATA && RREADY_S) begin
            rstate_d = (rlen_q == 4'd0) ? R_IDLE : R_DATA;
            if (rlen_q != 4'd0) begin
                rlen_d  = rlen_q - 4'd1;
                raddr_d = (rburst_q == 2'b00) ? raddr_q : raddr_q + 10'd1;
                {rerr_d, rdata_d} = rd_word(raddr_d);
            end
        end
    end
    always_comb begin
        wstate_d = wstate_q;
        bid_d    = bid_q;
        waddr_d  = waddr_q;
        wburst_d = wburst_q;
        werr_d   = werr_q;
        if (wstate_q == W_IDLE && AWVALID_S) begin
            wstate_d = W_DATA;
            bid_d    = AWID_S;
            waddr_d  = AWADDR_S[11:2];
            wburst_d = AWBURST_S;
            werr_d   = 1'b0;
        end else if (wbeat) begin
            werr_d   = werr_q | !wr_ok;
            waddr_d  = (wburst_q == 2'b00) ? waddr_q : waddr_q + 10'd1;
            wstate_d = WLAST_S ? W_RESP : W_DATA;
        end else if (wstate_q == W_RESP && BREADY_S) begin
            wstate_d = W_IDLE;
        end
    end
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            en_q     <= 1'b0;
            count_q  <= '0;
            wptr_q   <= '0;
            rstate_q <= R_IDLE;
            rid_q    <= '0;
            rlen_q   <= '0;
            raddr_q  <= '0;
            rburst_q <= '0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
            wstate_q <= W_IDLE;
            bid_q    <= '0;
            waddr_q  <= '0;
            wburst_q <= '0;
            werr_q   <= 1'b0;
        end else begin
            en_q     <= en_d;
            count_q  <= count_d;
            wptr_q   <= wptr_d;
            rstate_q <= rstate_d;
            rid_q    <= rid_d;
            rlen_q   <= rlen_d;
            raddr_q  <= raddr_d;
            rburst_q <= rburst_d;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
            wstate_q <= wstate_d;
            bid_q    <= bid_d;
            waddr_q  <= waddr_d;
            wburst_q <= wburst_d;
            werr_q   <= werr_d;
        end
    end
    // Clear drops a coincident sample
    always_ff @(posedge ACLK) if (cap && !clr) mem_q[wptr_q] <= sensor_out;
    assign ARREADY_S = rstate_q == R_IDLE;
    assign RVALID_S  = rstate_q == R_DATA;
    assign RLAST_S   = (rstate_q == R_DATA) && (rlen_q == 4'd0);
    assign RID_S     = rid_q;
    assign RDATA_S   = rdata_q;
    assign RRESP_S   = rerr_q ? 2'b10 : 2'b00;
    assign AWREADY_S = wstate_q == W_IDLE;
    assign WREADY_S  = wstate_q == W_DATA;
    assign BVALID_S  = wstate_q == W_RESP;
    assign BID_S     = bid_q;
    assign BRESP_S   = werr_q ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_sensor_buf_axi_slave.sv
// tb_sensor_buf_axi_slave: directed self-checking bench for sensor_buf_axi_slave at DEPTH=64.
module tb_sensor_buf_axi_slave;
    logic ACLK = 1'b0, ARESET = 1'b1;
    logic sensor_ready = 1'b0, sensor_en, sctrl_interrupt;
    logic [31:0] sensor_out = '0;
    logic [7:0] AWID_S = '0, BID_S, ARID_S = '0, RID_S;
    logic [31:0] AWADDR_S = '0, WDATA_S = '0, ARADDR_S = '0, RDATA_S;
    logic [3:0] AWLEN_S = '0, WSTRB_S = '0, ARLEN_S = '0;
    logic [2:0] AWSIZE_S = 3'd2, ARSIZE_S = 3'd2;
    logic [1:0] AWBURST_S = 2'b01, ARBURST_S = 2'b01, BRESP_S, RRESP_S;
    logic AWVALID_S = 1'b0, AWREADY_S, WLAST_S = 1'b0, WVALID_S = 1'b0, WREADY_S;
    logic BVALID_S, BREADY_S = 1'b0, ARVALID_S = 1'b0, ARREADY_S;
    logic RLAST_S, RVALID_S, RREADY_S = 1'b0;
    int n_chk = 0, n_err = 0;
    logic [31:0] d;
    logic [1:0] resp;
    logic [7:0] bid;

    sensor_buf_axi_slave #(.DEPTH(64), .IDW(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .sensor_ready(sensor_ready), .sensor_out(sensor_out),
        .sensor_en(sensor_en), .sctrl_interrupt(sctrl_interrupt),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
        .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
        .WREADY_S(WREADY_S),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end at a negedge
    task automatic aw_phase(input logic [31:0] a, input logic [3:0] len, input logic [7:0] id);
        int n = 0;
        AWADDR_S = a; AWLEN_S = len; AWID_S = id; AWBURST_S = 2'b01; AWVALID_S = 1'b1;
        while (!AWREADY_S && n < 50) begin @(negedge ACLK); n++; end
        chk("awready", AWREADY_S, 1);
        @(negedge ACLK);
        AWVALID_S = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        WDATA_S = data; WSTRB_S = strb; WLAST_S = last; WVALID_S = 1'b1;
        while (!WREADY_S && n < 50) begin @(negedge ACLK); n++; end
        chk("wready", WREADY_S, 1);
        @(negedge ACLK);
        WVALID_S = 1'b0; WLAST_S = 1'b0;
    endtask

    task automatic b_phase(output logic [1:0] r, output logic [7:0] id);
        int n = 0;
        BREADY_S = 1'b1;
        while (!BVALID_S && n < 50) begin @(negedge ACLK); n++; end
        chk("bvalid", BVALID_S, 1);
        r = BRESP_S; id = BID_S;
        @(negedge ACLK);
        BREADY_S = 1'b0;
    endtask

    task automatic write1(input logic [31:0] a, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] r);
        logic [7:0] id;
        aw_phase(a, 4'd0, 8'h3C);
        w_beat(data, strb, 1'b1);
        b_phase(r, id);
        chk("bid", id, 8'h3C);
    endtask

    task automatic read1(input logic [31:0] a, output logic [31:0] data, output logic [1:0] r);
        int n = 0;
        ARADDR_S = a; ARLEN_S = 4'd0; ARID_S = 8'h11; ARBURST_S = 2'b01; ARVALID_S = 1'b1;
        while (!ARREADY_S && n < 50) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        ARVALID_S = 1'b0; RREADY_S = 1'b1; n = 0;
        while (!RVALID_S && n < 50) begin @(negedge ACLK); n++; end
        chk("rvalid", RVALID_S, 1);
        chk("rlast_single", RLAST_S, 1);
        data = RDATA_S; r = RRESP_S;
        @(negedge ACLK);
        RREADY_S = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        chk("rst_arready", ARREADY_S, 1);
        chk("rst_awready", AWREADY_S, 1);
        chk("rst_sensor_en", sensor_en, 0);
        chk("rst_irq", sctrl_interrupt, 0);
        chk("rst_rvalid", RVALID_S, 0);
        chk("rst_bvalid", BVALID_S, 0);
        chk("rst_wready", WREADY_S, 0);
        chk("rst_rdata", RDATA_S, 0);
        read1(32'h808, d, resp);
        chk("rst_status", d, 0);
        chk("rst_status_resp", resp, 2'b00);

        // Fill to full
        write1(32'h800, 32'h1, 4'hF, resp);
        chk("ctrl_wr_resp", resp, 2'b00);
        chk("en_after_ctrl", sensor_en, 1);
        for (int i = 0; i < 70; i++) begin
            sensor_out = 32'hA000 + 32'(i); sensor_ready = 1'b1;
            if (i == 63) begin
                chk("en_at_63", sensor_en, 1);
                chk("irq_at_63", sctrl_interrupt, 0);
            end
            @(negedge ACLK);
        end
        sensor_ready = 1'b0;
        chk("full_sensor_en", sensor_en, 0);
        chk("full_irq", sctrl_interrupt, 1);
        read1(32'h808, d, resp);
        chk("full_status", d, 64);
        read1(32'h000, d, resp);
        chk("buf0", d, 32'hA000);
        read1(32'h0FC, d, resp);
        chk("buf63", d, 32'hA03F);
        chk("buf63_resp", resp, 2'b00);

        // INCR burst read with RREADY stall
        ARADDR_S = 32'h010; ARLEN_S = 4'd3; ARID_S = 8'h05; ARBURST_S = 2'b01; ARVALID_S = 1'b1;
        @(negedge ACLK);
        ARVALID_S = 1'b0; RREADY_S = 1'b1;
        chk("burst_arready_busy", ARREADY_S, 0);
        for (int b = 0; b < 4; b++) begin
            int n = 0;
            while (!RVALID_S && n < 50) begin @(negedge ACLK); n++; end
            chk("burst_rvalid", RVALID_S, 1);
            chk("burst_rdata", RDATA_S, 32'hA004 + 32'(b));
            chk("burst_rlast", RLAST_S, b == 3);
            chk("burst_rid", RID_S, 8'h05);
            if (b == 1) begin
                RREADY_S = 1'b0;
                @(negedge ACLK);
                chk("stall_rvalid", RVALID_S, 1);
                chk("stall_rdata", RDATA_S, 32'hA005);
                RREADY_S = 1'b1;
            end
            @(negedge ACLK);
        end
        RREADY_S = 1'b0;
        chk("burst_done", RVALID_S, 0);

        // Clear, then clear coinciding with a capture
        write1(32'h804, 32'h1, 4'hF, resp);
        chk("clr_irq", sctrl_interrupt, 0);
        chk("clr_sensor_en", sensor_en, 1);
        read1(32'h808, d, resp);
        chk("clr_status", d, 0);
        sensor_out = 32'hB000; sensor_ready = 1'b1;
        aw_phase(32'h804, 4'd0, 8'h07);
        w_beat(32'h1, 4'hF, 1'b1);
        sensor_ready = 1'b0;
        chk("clrcap_irq", sctrl_interrupt, 0);
        chk("clrcap_sensor_en", sensor_en, 1);
        b_phase(resp, bid);
        chk("clrcap_resp", resp, 2'b00);
        chk("clrcap_bid", bid, 8'h07);
        read1(32'h808, d, resp);
        chk("clrcap_status", d, 0);
        sensor_out = 32'hC000; sensor_ready = 1'b1;
        @(negedge ACLK);
        sensor_ready = 1'b0;
        read1(32'h808, d, resp);
        chk("postclr_status", d, 1);
        read1(32'h000, d, resp);
        chk("postclr_buf0", d, 32'hC000);
        read1(32'h804, d, resp);
        chk("clear_reads0", d, 0);

        // Error responses
        write1(32'h004, 32'hDEAD, 4'hF, resp);
        chk("buf_wr_slverr", resp, 2'b10);
        read1(32'h004, d, resp);
        chk("buf1_unchanged", d, 32'hA001);
        chk("buf1_resp", resp, 2'b00);
        read1(32'h900, d, resp);
        chk("unmapped_rdata", d, 0);
        chk("unmapped_rresp", resp, 2'b10);
        write1(32'h808, 32'h5, 4'hF, resp);
        chk("status_wr_slverr", resp, 2'b10);
        aw_phase(32'h800, 4'd1, 8'h2A);
        w_beat(32'h0, 4'hF, 1'b0);
        w_beat(32'h1, 4'hF, 1'b1);
        b_phase(resp, bid);
        chk("burst_wr_resp", resp, 2'b00);
        chk("burst_wr_bid", bid, 8'h2A);
        chk("burst_wr_en", sensor_en, 0);
        read1(32'h808, d, resp);
        chk("burst_wr_status", d, 0);
        read1(32'h800, d, resp);
        chk("ctrl_read", d, 0);
        write1(32'h800, 32'h1, 4'h0, resp);
        chk("strb0_resp", resp, 2'b00);
        chk("strb0_en", sensor_en, 0);
        write1(32'h800, 32'h1, 4'hF, resp);
        chk("ctrl_reenable", sensor_en, 1);

`ifdef SCTRL_THRESH_EN
        write1(32'h80C, 32'd4, 4'hF, resp);
        chk("thr_wr_resp", resp, 2'b00);
        read1(32'h80C, d, resp);
        chk("thr_read4", d, 4);
        for (int i = 0; i < 4; i++) begin
            sensor_out = 32'hD000 + 32'(i); sensor_ready = 1'b1;
            chk("thr_irq_before", sctrl_interrupt, 0);
            @(negedge ACLK);
        end
        sensor_ready = 1'b0;
        chk("thr_irq_after4", sctrl_interrupt, 1);
        write1(32'h80C, 32'd100, 4'hF, resp);
        read1(32'h80C, d, resp);
        chk("thr_saturate", d, 64);
        chk("thr_irq_64", sctrl_interrupt, 0);
        write1(32'h80C, 32'd0, 4'hF, resp);
        read1(32'h80C, d, resp);
        chk("thr_zero_as_one", d, 1);
        chk("thr_irq_1", sctrl_interrupt, 1);
`else
        read1(32'h80C, d, resp);
        chk("thr_fixed", d, 64);
        chk("thr_fixed_resp", resp, 2'b00);
        write1(32'h80C, 32'd4, 4'hF, resp);
        chk("thr_wr_ignored_resp", resp, 2'b00);
        read1(32'h80C, d, resp);
        chk("thr_still64", d, 64);
        chk("thr_irq", sctrl_interrupt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
